// File: rtl/fpx_pkg.sv
// rtl/fpx_pkg.sv - shared types, flag indices and constant builders for the reciprocal unit
package fpx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fpx_state_e;

  localparam int FLAG_INVALID     = 0;
  localparam int FLAG_DIV_BY_ZERO = 1;
  localparam int FLAG_UNDERFLOW   = 2;
  localparam int FLAG_INEXACT     = 3;

  // Builders return a wide vector; callers keep the low 1+exp_w+man_w bits.
  localparam int FPX_MAX_W = 128;

  function automatic int fpx_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FPX_MAX_W-1:0] fpx_inf(input int exp_w, input int man_w);
    logic [FPX_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
    return v;
  endfunction

  function automatic logic [FPX_MAX_W-1:0] fpx_qnan(input int exp_w, input int man_w);
    logic [FPX_MAX_W-1:0] v;
    v = fpx_inf(exp_w, man_w);
    v[man_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpx_mant_divider.sv
// rtl/fpx_mant_divider.sv - restoring division 2/(1.frac), one quotient bit per cycle
module fpx_mant_divider #(
  parameter int MAN_W = 52
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             start,
  input  logic [MAN_W-1:0] divisor_frac,
  output logic             busy,
  output logic             last,
  output logic [MAN_W+1:0] quotient,
  output logic             sticky
);

  // Remainder stays below 2*divisor < 4 after each shift, scaled by 2^MAN_W.
  localparam int RW = MAN_W + 3;
  localparam int CW = $clog2(MAN_W + 3);

  logic [RW-1:0] rem;
  logic [RW-1:0] divisor;
  logic [RW-1:0] diff;
  logic          ge;
  logic [CW-1:0] count;

  always_comb begin
    ge   = (rem >= divisor);
    diff = rem - divisor;
  end

  always_ff @(posedge clk) begin
    if (!rset) begin
      busy     <= 1'b0;
      count    <= '0;
      rem      <= '0;
      divisor  <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= CW'(MAN_W + 2);
      rem      <= RW'(1) << (MAN_W + 1);
      divisor  <= {3'b001, divisor_frac};
      quotient <= '0;
    end else if (busy) begin
      quotient <= {quotient[MAN_W:0], ge};
      rem      <= (ge ? diff : rem) << 1;
      count    <= count - CW'(1);
      if (count == CW'(1)) busy <= 1'b0;
    end
  end

  assign last   = busy && (count == CW'(1));
  assign sticky = (rem != '0);

endmodule

// File: rtl/fpx_reciprocal.sv
// rtl/fpx_reciprocal.sv - handshaked IEEE-754 style reciprocal with RNE rounding and flush-to-zero
module fpx_reciprocal
  import fpx_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   rcprcl_input,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   rcprcl_output,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = fpx_bias(EXP_W);
  localparam logic [FPX_MAX_W-1:0] INF_FULL  = fpx_inf(EXP_W, MAN_W);
  localparam logic [FPX_MAX_W-1:0] QNAN_FULL = fpx_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] INF_MAG = INF_FULL[W-1:0];
  localparam logic [W-1:0] QNAN    = QNAN_FULL[W-1:0];

  fpx_state_e state;

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_frac;
  logic             accept;
  logic             is_regular;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;
  logic signed [EW-1:0] pow_er;

  logic             sign_q;
  logic [EXP_W-1:0] exp_q;

  logic             div_start;
  logic             div_busy;
  logic             div_last;
  logic [MAN_W+1:0] quotient;
  logic             sticky;

  logic             guard;
  logic             round_up;
  logic             carry;
  logic [MAN_W+1:0] mant_sum;
  logic signed [EW-1:0] reg_er;
  logic [W-1:0]     reg_res;
  logic [3:0]       reg_flags;

  assign {in_sign, in_exp, in_frac} = rcprcl_input;
  assign accept    = in_valid && in_ready && (state == IDLE);
  assign div_start = accept && is_regular;

  // Classification of the offered operand; everything but regular normals resolves here.
  always_comb begin
    spec_res   = '0;
    spec_flags = '0;
    is_regular = 1'b0;
    pow_er     = EW'(2 * BIAS) - $signed({2'b00, in_exp});
    if (&in_exp) begin
      if (~|in_frac) begin
        spec_res = {in_sign, {(W-1){1'b0}}};
      end else begin
        spec_res                 = QNAN;
        spec_flags[FLAG_INVALID] = ~in_frac[MAN_W-1];
      end
    end else if (~|in_exp) begin
      spec_res                     = INF_MAG | {in_sign, {(W-1){1'b0}}};
      spec_flags[FLAG_DIV_BY_ZERO] = 1'b1;
    end else if (~|in_frac) begin
      if (pow_er[EW-1] || (pow_er == '0)) begin
        spec_res                   = {in_sign, {(W-1){1'b0}}};
        spec_flags[FLAG_UNDERFLOW] = 1'b1;
        spec_flags[FLAG_INEXACT]   = 1'b1;
      end else begin
        spec_res = {in_sign, pow_er[EXP_W-1:0], {MAN_W{1'b0}}};
      end
    end else begin
      is_regular = 1'b1;
    end
  end

  fpx_mant_divider #(.MAN_W(MAN_W)) u_div (
    .clk          (clk),
    .rset         (rset),
    .start        (div_start),
    .divisor_frac (in_frac),
    .busy         (div_busy),
    .last         (div_last),
    .quotient     (quotient),
    .sticky       (sticky)
  );

  // quotient = {integer bit, MAN_W fraction bits, guard}; the integer bit is always set here.
  always_comb begin
    guard     = quotient[0];
    round_up  = guard & (sticky | quotient[1]);
    mant_sum  = {1'b0, quotient[MAN_W+1:1]} + (MAN_W+2)'(round_up);
    carry     = mant_sum[MAN_W+1];
    reg_er    = EW'(2 * BIAS - 1) - $signed({2'b00, exp_q}) + $signed({{(EW-1){1'b0}}, carry});
    reg_flags = '0;
    reg_flags[FLAG_INEXACT] = guard | sticky;
    if (reg_er[EW-1] || (reg_er == '0)) begin
      reg_res                   = {sign_q, {(W-1){1'b0}}};
      reg_flags[FLAG_UNDERFLOW] = 1'b1;
      reg_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      reg_res = {sign_q, reg_er[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      rcprcl_output <= '0;
      flags         <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q   <= in_sign;
            exp_q    <= in_exp;
            in_ready <= 1'b0;
            if (is_regular) begin
              state <= DIV;
            end else begin
              state         <= DONE;
              out_valid     <= 1'b1;
              rcprcl_output <= spec_res;
              flags         <= spec_flags;
            end
          end
        end
        DIV: begin
          if (div_busy && div_last) state <= ROUND;
        end
        ROUND: begin
          state         <= DONE;
          out_valid     <= 1'b1;
          rcprcl_output <= reg_res;
          flags         <= reg_flags;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpx_reciprocal.sv
// tb/tb_fpx_reciprocal.sv - randomized self-checking bench for double and single reciprocal instances
module tb_fpx_reciprocal;

  logic        clk = 1'b0;
  logic        rset = 1'b0;

  logic        d_iv, d_ir, d_ov, d_or;
  logic [63:0] d_in, d_out;
  logic [3:0]  d_fl;
  logic        s_iv, s_ir, s_ov, s_or;
  logic [31:0] s_in, s_out;
  logic [3:0]  s_fl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpx_reciprocal u_dbl (
    .clk(clk), .rset(rset), .in_valid(d_iv), .in_ready(d_ir), .rcprcl_input(d_in),
    .out_valid(d_ov), .out_ready(d_or), .rcprcl_output(d_out), .flags(d_fl)
  );

  fpx_reciprocal #(.EXP_W(8), .MAN_W(23)) u_sgl (
    .clk(clk), .rset(rset), .in_valid(s_iv), .in_ready(s_ir), .rcprcl_input(s_in),
    .out_valid(s_ov), .out_ready(s_or), .rcprcl_output(s_out), .flags(s_fl)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Double reference: host IEEE division gives the correctly rounded reciprocal.
  function automatic void model_d(input logic [63:0] x, output logic [63:0] r,
                                  output logic [3:0] f, output int lat);
    logic s; logic [10:0] e; logic [51:0] m;
    s = x[63]; e = x[62:52]; m = x[51:0];
    f = '0; lat = 0; r = '0;
    if (e == 11'h7FF) begin
      if (m == 0) r = {s, 63'b0};
      else begin r = 64'h7FF8000000000000; f[0] = ~m[51]; end
    end else if (e == 0) begin
      r = {s, 11'h7FF, 52'b0}; f[1] = 1'b1;
    end else begin
      lat = (m == 0) ? 0 : 55;
      if (e >= 11'd2046 || (e == 11'd2045 && m != 0)) begin
        r = {s, 63'b0}; f = 4'b1100;
      end else begin
        r = $realtobits(1.0 / $bitstoreal(x));
        f[3] = (m != 0);
      end
    end
  endfunction

  // Single reference: integer long division of 2^47 by the 24-bit significand.
  function automatic void model_s(input logic [31:0] x, output logic [63:0] r,
                                  output logic [3:0] f, output int lat);
    logic s; logic [7:0] e; logic [22:0] m; logic [63:0] mm, q, rem; int ex;
    s = x[31]; e = x[30:23]; m = x[22:0];
    f = '0; lat = 0; r = '0;
    if (e == 8'hFF) begin
      if (m == 0) r = {32'b0, s, 31'b0};
      else begin r = 64'h7FC00000; f[0] = ~m[22]; end
    end else if (e == 0) begin
      r = {32'b0, s, 8'hFF, 23'b0}; f[1] = 1'b1;
    end else if (e >= 8'd254 || (e == 8'd253 && m != 0)) begin
      r = {32'b0, s, 31'b0}; f = 4'b1100; lat = (m == 0) ? 0 : 26;
    end else if (m == 0) begin
      ex = 254 - int'(e);
      r = {32'b0, s, ex[7:0], 23'b0};
    end else begin
      lat = 26; f[3] = 1'b1;
      mm  = 64'h800000 | {41'b0, m};
      q   = (64'd1 << 47) / mm;
      rem = (64'd1 << 47) % mm;
      if (2 * rem > mm || (2 * rem == mm && q[0])) q = q + 1;
      ex = 253 - int'(e);
      if (q == 64'h1000000) begin q = 64'h800000; ex++; end
      r = {32'b0, s, ex[7:0], q[22:0]};
    end
  endfunction

  function automatic logic [63:0] rand_d();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v[62:52] = '0;
      1: v[62:52] = 11'h7FF;
      2: v[51:0]  = '0;
      3: v[62:52] = 11'(2043 + $urandom_range(0, 3));
      4: v[62:52] = 11'(1 + $urandom_range(0, 2));
      default: if (v[62:52] == 0 || v[62:52] == 11'h7FF) v[62:52] = 11'h3FF;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] rand_s();
    logic [63:0] v;
    v = {32'b0, $urandom};
    case ($urandom_range(0, 9))
      0: v[30:23] = '0;
      1: v[30:23] = 8'hFF;
      2: v[22:0]  = '0;
      3: v[30:23] = 8'(251 + $urandom_range(0, 3));
      4: v[30:23] = 8'(1 + $urandom_range(0, 2));
      default: if (v[30:23] == 0 || v[30:23] == 8'hFF) v[30:23] = 8'h7F;
    endcase
    return v;
  endfunction

  task automatic run_op(input bit sgl, input logic [63:0] x, input int hold);
    logic [63:0] want; logic [3:0] wf; int wl, lat;
    if (sgl) model_s(x[31:0], want, wf, wl);
    else     model_d(x, want, wf, wl);
    @(negedge clk);
    chk("in_ready_idle", sgl ? s_ir : d_ir, 1);
    if (sgl) begin s_iv = 1'b1; s_in = x[31:0]; end
    else     begin d_iv = 1'b1; d_in = x; end
    @(posedge clk); #1;
    s_iv = 1'b0; d_iv = 1'b0;
    lat = 0;
    while (!(sgl ? s_ov : d_ov) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, wl);
    for (int i = 0; i <= hold; i++) begin
      chk("result", sgl ? {32'b0, s_out} : d_out, want);
      chk("flags", sgl ? s_fl : d_fl, wf);
      if (hold > 0) begin
        chk("out_valid_held", sgl ? s_ov : d_ov, 1);
        chk("in_ready_busy", sgl ? s_ir : d_ir, 0);
      end
      if (i < hold) begin @(posedge clk); #1; end
    end
    if (sgl) s_or = 1'b1; else d_or = 1'b1;
    @(posedge clk); #1;
    s_or = 1'b0; d_or = 1'b0;
    chk("in_ready_after_pop", sgl ? s_ir : d_ir, 1);
    chk("out_valid_after_pop", sgl ? s_ov : d_ov, 0);
  endtask

  task automatic reset_mid_div();
    int seen;
    seen = 0;
    @(negedge clk); d_iv = 1'b1; d_in = 64'h4008000000000000;
    @(posedge clk); #1; d_iv = 1'b0;
    repeat (20) @(posedge clk);
    #1; rset = 1'b0; d_iv = 1'b1;
    @(posedge clk); #1; rset = 1'b1; d_iv = 1'b0;
    chk("rst_in_ready", d_ir, 1);
    chk("rst_out_valid", d_ov, 0);
    chk("rst_output", d_out, 0);
    chk("rst_flags", d_fl, 0);
    repeat (80) begin
      @(posedge clk); #1;
      if (d_ov) seen++;
    end
    chk("no_result_after_reset", seen, 0);
  endtask

  initial begin
    d_iv = 0; d_or = 0; d_in = '0;
    s_iv = 0; s_or = 0; s_in = '0;
    rset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_d_in_ready", d_ir, 1);
    chk("init_d_out_valid", d_ov, 0);
    chk("init_d_output", d_out, 0);
    chk("init_d_flags", d_fl, 0);
    chk("init_s_in_ready", s_ir, 1);
    chk("init_s_out_valid", s_ov, 0);
    rset = 1'b1;

    run_op(1'b0, 64'h4000000000000000, 0);
    run_op(1'b0, 64'h4008000000000000, 0);
    run_op(1'b0, 64'h0000000000000000, 0);
    run_op(1'b0, 64'hFFF0000000000000, 0);
    run_op(1'b0, 64'h7FE0000000000001, 0);
    run_op(1'b0, 64'h7FF0000000000001, 0);
    run_op(1'b0, 64'h7FF8000000000001, 0);
    run_op(1'b0, 64'h800FFFFFFFFFFFFF, 0);
    run_op(1'b0, 64'hC008000000000000, 0);
    run_op(1'b0, 64'h4008000000000000, 10);
    reset_mid_div();

    run_op(1'b1, 64'h40000000, 0);
    run_op(1'b1, 64'h40400000, 0);
    run_op(1'b1, 64'h3FFFFFFF, 0);
    run_op(1'b1, 64'h7F000001, 3);

    for (int i = 0; i < 40; i++) run_op(1'b0, rand_d(), $urandom_range(0, 2));
    for (int i = 0; i < 40; i++) run_op(1'b1, rand_s(), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpx_reciprocal.md
FPX_RECIPROCAL -- requirements
Module: fpx_reciprocal

Interface
REQ-001 Parameter EXP_W, default 11, exponent field width.
REQ-002 Parameter MAN_W, default 52, fraction field width; total operand width W = 1+EXP_W+MAN_W (default 64).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rset  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block can accept operand.
REQ-007 rcprcl_input  input  W  IEEE-754-format operand {sign, exp, frac}.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 rcprcl_output  output  W  reciprocal 1/x.
REQ-011 flags  output  4  {inexact, underflow, div_by_zero, invalid}, valid with out_valid.

Function
REQ-012 The block SHALL use FSM states IDLE, DIV, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready captures the operand at that edge.
REQ-014 Special/exact operands SHALL go IDLE->DONE at the accept edge: out_valid is high in the cycle after the accept edge.
REQ-015 Regular operands (normal exp, frac != 0) SHALL go IDLE->DIV; DIV lasts exactly MAN_W+2 cycles, producing one quotient bit per cycle; then ROUND for 1 cycle; then DONE. out_valid rises MAN_W+3 edges after accept (55 for defaults).
REQ-016 DONE SHALL hold rcprcl_output, flags and out_valid stable until out_ready=1; DONE & out_ready -> IDLE at that edge. out_ready is ignored outside DONE.
REQ-017 Regular path: mantissa quotient = 2/(1.f) by restoring division (MAN_W+1 significant bits + guard); sticky = remainder != 0; biased exponent Er = 2*BIAS - e - 1, with BIAS = 2^(EXP_W-1)-1.
REQ-018 Exact power of two (frac = 0, normal e): result frac = 0, Er = 2*BIAS - e, sign preserved.
REQ-019 Rounding SHALL be round-to-nearest-even on guard/sticky; a mantissa carry to 2.0 SHALL increment Er and clear frac.
REQ-020 Er <= 0 SHALL flush to signed zero with underflow=1 and inexact=1; overflow cannot occur for normal inputs.
REQ-021 inexact SHALL equal guard|sticky on the regular path, 0 for exact results.
REQ-022 ±zero or denormal input (exp=0, denormal flushed to zero) SHALL give ±inf, div_by_zero=1.
REQ-023 ±inf SHALL give ±zero, no flags.
REQ-024 NaN input SHALL give canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 only for sNaN (frac MSB 0).
REQ-025 Output sign SHALL equal input sign for all non-NaN cases.

Reset
REQ-026 rset=0 at a rising edge SHALL force IDLE, out_valid=0, rcprcl_output=0, flags=0, in_ready=1 in the following cycle, from any state.
REQ-027 An operation in progress when reset is asserted SHALL be discarded; no result is emitted afterwards.
REQ-028 in_valid during reset SHALL NOT be accepted.

Structure
REQ-029 Package fpx_pkg SHALL hold the state enum, flag bit indices, the BIAS function of EXP_W, and the qNaN/inf constant builders.
REQ-030 The mantissa iteration SHALL be a sub-module fpx_mant_divider (start, busy, quotient, sticky), parametrised by MAN_W.
REQ-031 Classification, exponent arithmetic, rounding and the FSM SHALL stay in fpx_reciprocal.

Verification
REQ-032 0x4000000000000000 (2.0) -> 0x3FE0000000000000, flags 0, out_valid one cycle after accept.
REQ-033 0x4008000000000000 (3.0) -> 0x3FD5555555555555, flags inexact only, out_valid 55 edges after accept.
REQ-034 0x0000000000000000 -> 0x7FF0000000000000, div_by_zero; 0xFFF0000000000000 -> 0x8000000000000000, flags 0.
REQ-035 0x7FE0000000000001 -> 0x0000000000000000, underflow+inexact; 0x7FF0000000000001 -> 0x7FF8000000000000, invalid.
REQ-036 3.0 with out_ready low 10 cycles after out_valid -> output and flags stable; in_ready stays 0; IDLE one edge after out_ready=1.
REQ-037 rset low 20 cycles into DIV -> IDLE next cycle, no out_valid; repeat REQ-032/033 at EXP_W=8, MAN_W=23: 0x40400000 -> 0x3EAAAAAB, latency 26.
